// File: rtl/rx_ring_packer.sv
// Packs RGB888 pixels two-per-48-bit word into a 32-entry ring RAM, tracking
// occupancy against the consumer read pointer and flagging frames that restart mid-word.
//
//   state    | meaning
//   WAIT_SOF | no frame open, pixels discarded until start-of-frame
//   PACK_LO  | in frame, no pixel held
//   PACK_HI  | in frame, low-half pixel held awaiting its partner
module rx_ring_packer (
    input  logic        wr_clk,
    input  logic        wr_rst_n,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic        pix_eol,
    output logic        pix_ready,
    input  logic [5:0]  rd_ptr,
    output logic        ring_wr_en,
    output logic [4:0]  ring_wr_addr,
    output logic [47:0] ring_wr_data,
    output logic [5:0]  ring_wr_byte_en,
    output logic [5:0]  wr_ptr,
    output logic [5:0]  level,
    output logic        full,
    output logic        sof_err
);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PACK_LO  = 2'd1,
        PACK_HI  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] held_q, held_d;
    logic [5:0]  wr_ptr_q, wr_ptr_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  addr_q, addr_d;
    logic [47:0] data_q, data_d;
    logic [5:0]  be_q, be_d;
    logic        sof_err_q, sof_err_d;
    logic        accept;

    // Wrapping difference: any value with bit 5 set means 32 or more words outstanding.
    assign level     = wr_ptr_q - rd_ptr;
    assign full      = level[5];
    assign pix_ready = wr_rst_n && !full;
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        wr_ptr_d  = wr_ptr_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        sof_err_d = sof_err_q;
        if (accept) begin
            if (pix_sof) begin
                if (state_q == PACK_HI) begin
                    sof_err_d = 1'b1;
                end
                if (pix_eol) begin
                    wr_en_d  = 1'b1;
                    addr_d   = wr_ptr_q[4:0];
                    data_d   = {24'h0, pix_data};
                    be_d     = 6'b000111;
                    wr_ptr_d = wr_ptr_q + 6'd1;
                    state_d  = PACK_LO;
                end else begin
                    held_d  = pix_data;
                    state_d = PACK_HI;
                end
            end else begin
                case (state_q)
                    PACK_LO: begin
                        if (pix_eol) begin
                            wr_en_d  = 1'b1;
                            addr_d   = wr_ptr_q[4:0];
                            data_d   = {24'h0, pix_data};
                            be_d     = 6'b000111;
                            wr_ptr_d = wr_ptr_q + 6'd1;
                        end else begin
                            held_d  = pix_data;
                            state_d = PACK_HI;
                        end
                    end
                    PACK_HI: begin
                        wr_en_d  = 1'b1;
                        addr_d   = wr_ptr_q[4:0];
                        data_d   = {pix_data, held_q};
                        be_d     = 6'b111111;
                        wr_ptr_d = wr_ptr_q + 6'd1;
                        state_d  = PACK_LO;
                    end
                    default: state_d = WAIT_SOF;
                endcase
            end
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q   <= WAIT_SOF;
            held_q    <= 24'h0;
            wr_ptr_q  <= 6'd0;
            wr_en_q   <= 1'b0;
            addr_q    <= 5'd0;
            data_q    <= 48'h0;
            be_q      <= 6'd0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign wr_ptr          = wr_ptr_q;
    assign ring_wr_en      = wr_en_q;
    assign ring_wr_addr    = addr_q;
    assign ring_wr_data    = data_q;
    assign ring_wr_byte_en = be_q;
    assign sof_err         = sof_err_q;

endmodule

// File: tb/tb_rx_ring_packer.sv
// Randomized and directed bench for rx_ring_packer against a line-buffer reference model.
module tb_rx_ring_packer;

    logic        wr_clk = 1'b0;
    logic        wr_rst_n;
    logic [23:0] pix_data;
    logic        pix_valid, pix_sof, pix_eol;
    logic        pix_ready;
    logic [5:0]  rd_ptr;
    logic        ring_wr_en;
    logic [4:0]  ring_wr_addr;
    logic [47:0] ring_wr_data;
    logic [5:0]  ring_wr_byte_en;
    logic [5:0]  wr_ptr, level;
    logic        full, sof_err;

    always #5 wr_clk = ~wr_clk;

    rx_ring_packer dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_ready(pix_ready), .rd_ptr(rd_ptr),
        .ring_wr_en(ring_wr_en), .ring_wr_addr(ring_wr_addr), .ring_wr_data(ring_wr_data),
        .ring_wr_byte_en(ring_wr_byte_en), .wr_ptr(wr_ptr), .level(level), .full(full),
        .sof_err(sof_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: words written so far, consumer position, pixels of the open word.
    int          wcount, rd;
    bit          in_frame, sof_err_m, exp_wr;
    logic [23:0] pend[$];
    logic [4:0]  last_addr;
    logic [47:0] last_data;
    logic [5:0]  last_be;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int model_level();
        return (wcount - rd) & 63;
    endfunction

    task automatic model_reset();
        wcount = 0; rd = 0; in_frame = 0; sof_err_m = 0; exp_wr = 0;
        pend.delete();
        last_addr = '0; last_data = '0; last_be = '0;
    endtask

    // Called at a falling edge; presents one input cycle and checks the registered result.
    task automatic cycle(input bit v, input logic [23:0] d, input bit s, input bit e);
        bit acc;
        rd_ptr = rd[5:0];
        pix_valid = v; pix_data = d; pix_sof = s; pix_eol = e;
        #1;
        chk("ready", 64'(pix_ready), 64'(model_level() < 32));
        acc = v && (model_level() < 32);
        exp_wr = 0;
        if (acc) begin
            if (s) begin
                if (pend.size() == 1) sof_err_m = 1;
                pend.delete();
                in_frame = 1;
            end
            if (in_frame) begin
                pend.push_back(d);
                if (e || pend.size() == 2) begin
                    exp_wr    = 1;
                    last_addr = 5'(wcount % 32);
                    if (pend.size() == 2) begin
                        last_data = {pend[1], pend[0]};
                        last_be   = 6'b111111;
                    end else begin
                        last_data = {24'h0, pend[0]};
                        last_be   = 6'b000111;
                    end
                    wcount++;
                    pend.delete();
                end
            end
        end
        @(posedge wr_clk);
        @(negedge wr_clk);
        chk("wr_en",   64'(ring_wr_en),      64'(exp_wr));
        chk("wr_addr", 64'(ring_wr_addr),    64'(last_addr));
        chk("wr_data", 64'(ring_wr_data),    64'(last_data));
        chk("wr_be",   64'(ring_wr_byte_en), 64'(last_be));
        chk("wr_ptr",  64'(wr_ptr),          64'(wcount & 63));
        chk("level",   64'(level),           64'(model_level()));
        chk("full",    64'(full),            64'(model_level() >= 32));
        chk("sof_err", 64'(sof_err),         64'(sof_err_m));
    endtask

    // Asserts reset at a falling edge, checks the asynchronous clear, releases two edges later.
    task automatic do_reset();
        wr_rst_n = 1'b0;
        pix_valid = 0; pix_sof = 0; pix_eol = 0; pix_data = '0;
        model_reset();
        rd_ptr = 6'd0;
        #1;
        chk("rst_ready",   64'(pix_ready),       64'(0));
        chk("rst_wr_ptr",  64'(wr_ptr),          64'(0));
        chk("rst_wr_en",   64'(ring_wr_en),      64'(0));
        chk("rst_addr",    64'(ring_wr_addr),    64'(0));
        chk("rst_data",    64'(ring_wr_data),    64'(0));
        chk("rst_be",      64'(ring_wr_byte_en), 64'(0));
        chk("rst_sof_err", 64'(sof_err),         64'(0));
        @(negedge wr_clk);
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
    endtask

    initial begin
        wr_rst_n = 1'b1;
        rd_ptr = '0; pix_valid = 0; pix_sof = 0; pix_eol = 0; pix_data = '0;
        model_reset();
        @(negedge wr_clk);
        do_reset();

        // Two full words from a four-pixel line.
        cycle(1, 24'h000001, 1, 0);
        cycle(1, 24'h000002, 0, 0);
        chk("r36_word0", 64'(ring_wr_data), 64'(48'h000002000001));
        cycle(1, 24'h000003, 0, 0);
        cycle(1, 24'h000004, 0, 1);
        chk("r36_word1", 64'(ring_wr_data), 64'(48'h000004000003));
        chk("r36_addr1", 64'(ring_wr_addr), 64'(1));
        chk("r36_level", 64'(level), 64'(2));

        // Odd line leaves a half word with low byte enables.
        cycle(1, 24'h000011, 0, 0);
        cycle(1, 24'h000012, 0, 0);
        cycle(1, 24'h000013, 0, 1);
        chk("r37_data", 64'(ring_wr_data), 64'(48'h000000000013));
        chk("r37_be",   64'(ring_wr_byte_en), 64'(6'h07));

        // Fill the ring, then free one slot.
        do_reset();
        for (int i = 0; i < 64; i++) cycle(1, 24'(i + 24'h100), i == 0, 0);
        chk("r38_full",  64'(full), 64'(1));
        chk("r38_ready", 64'(pix_ready), 64'(0));
        cycle(1, 24'hABCDEF, 0, 0);
        rd = 1;
        cycle(1, 24'h000aaa, 0, 0);
        cycle(1, 24'h000bbb, 0, 0);
        chk("r38_addr",   64'(ring_wr_addr), 64'(0));
        chk("r38_wr_ptr", 64'(wr_ptr), 64'(33));

        // Pixels without a frame start are dropped.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 24'(i + 5), 0, i == 4);
        chk("r39_wr_ptr", 64'(wr_ptr), 64'(0));

        // Frame restart while a pixel is held.
        do_reset();
        cycle(1, 24'h0000AA, 1, 0);
        cycle(1, 24'h0000BB, 1, 0);
        cycle(1, 24'h0000CC, 0, 0);
        chk("r40_sof_err", 64'(sof_err), 64'(1));
        chk("r40_data", 64'(ring_wr_data), 64'(48'h0000CC0000BB));
        cycle(0, 24'h0, 0, 0);
        chk("r40_sticky", 64'(sof_err), 64'(1));

        // Reset while holding a pixel.
        do_reset();
        cycle(1, 24'h000031, 0, 0);
        cycle(1, 24'h000032, 1, 0);
        do_reset();
        cycle(1, 24'h000033, 0, 0);
        cycle(1, 24'h000034, 0, 0);
        chk("r41_wr_ptr", 64'(wr_ptr), 64'(0));

        // Random traffic with a bursty consumer, including a reset midway.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit drain;
            drain = ((i / 150) % 2) == 0;
            if (i == 1500) do_reset();
            if (drain && ($urandom % 3 == 0)) rd = rd + int'($urandom_range(0, model_level()));
            cycle($urandom % 4 != 0, 24'($urandom()), $urandom % 25 == 0, $urandom % 7 == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_ring_packer.md
RX_RING_PACKER -- requirements
Module: rx_ring_packer

Interface
REQ-001 SHALL: wr_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: wr_rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL: pix_data  input  24  RGB888 pixel.
REQ-004 SHALL: pix_valid  input  1  pixel present.
REQ-005 SHALL: pix_sof  input  1  first pixel of frame; qualified by pix_valid.
REQ-006 SHALL: pix_eol  input  1  last pixel of line; qualified by pix_valid.
REQ-007 SHALL: pix_ready  output  1  packer accepts pixel this cycle.
REQ-008 SHALL: rd_ptr  input  6  consumer read pointer, same clock domain, wraps mod 64.
REQ-009 SHALL: ring_wr_en  output  1  write strobe to the 32x48 ring RAM.
REQ-010 SHALL: ring_wr_addr  output  5  ring write address.
REQ-011 SHALL: ring_wr_data  output  48  packed word.
REQ-012 SHALL: ring_wr_byte_en  output  6  byte enables, bit n covers data[8n+7:8n].
REQ-013 SHALL: wr_ptr  output  6  write pointer, wraps mod 64.
REQ-014 SHALL: level  output  6  occupancy, wr_ptr - rd_ptr mod 64.
REQ-015 SHALL: full  output  1  level >= 32.
REQ-016 SHALL: sof_err  output  1  sticky: frame start arrived with half-packed word pending.

Function
REQ-017 SHALL: accept a pixel on a rising edge where pix_valid && pix_ready.
REQ-018 SHALL: drive pix_ready = !full while wr_rst_n high, 0 while wr_rst_n low.
REQ-019 SHALL: implement states WAIT_SOF, PACK_LO (no held pixel) and PACK_HI (low pixel held).
REQ-020 SHALL: in WAIT_SOF, discard accepted pixels without pix_sof and perform no write.
REQ-021 SHALL: on accepted pix_sof without pix_eol, from any state, hold pixel as low half and go to PACK_HI.
REQ-022 SHALL: on accepted pix_sof in PACK_HI, drop the held pixel and set sof_err.
REQ-023 SHALL: in PACK_LO, on an accepted pixel without eol, hold it and go to PACK_HI with no write.
REQ-024 SHALL: in PACK_HI, on an accepted pixel, write {pixel, held} with byte_en 6'b111111 and go to PACK_LO.
REQ-025 SHALL: in PACK_LO (or with sof), on an accepted pixel with eol, write {24'h0, pixel} with byte_en 6'b000111 and go to PACK_LO.
REQ-026 SHALL: register writes: ring_wr_en high exactly one cycle after the accepting edge, with ring_wr_addr = wr_ptr[4:0] before increment.
REQ-027 SHALL: increment wr_ptr on the same edge that asserts ring_wr_en, so level/full reflect the write in the next cycle.
REQ-028 SHALL: hold ring_wr_data, ring_wr_addr and ring_wr_byte_en at the last written values when ring_wr_en is low.
REQ-029 SHALL: compute level combinationally from wr_ptr and rd_ptr, using a 6-bit wrapping subtraction.
REQ-030 SHALL: treat level values 32..63 as full, and never write while full.
REQ-031 SHALL: wrap ring_wr_addr from 31 to 0, and wr_ptr from 63 to 0.
REQ-032 SHALL: sustain one accepted pixel per cycle when not full, giving a maximum of one write every two cycles for even lines.

Reset
REQ-033 SHALL: on wr_rst_n low, immediately enter WAIT_SOF, discard any held pixel, and clear wr_ptr, ring_wr_en, ring_wr_addr, ring_wr_data, ring_wr_byte_en and sof_err to 0.
REQ-034 SHALL: on reset release, accept the first pixel only on the first rising edge with wr_rst_n high.
REQ-035 SHALL: clear sof_err only by reset.

Verification
REQ-036 SHALL: After reset with rd_ptr=0, send sof+0x000001, 0x000002, 0x000003, eol+0x000004 -> expect writes addr0 = 0x000002000001 and addr1 = 0x000004000003, both byte_en 3F; wr_ptr=2; level=2.
REQ-037 SHALL: Send a 3-pixel line 0x000011, 0x000012, eol+0x000013 -> expect a second write of 0x000000000013 with byte_en 07.
REQ-038 SHALL: Hold rd_ptr=0 and stream 64 pixels -> expect 32 writes, then full=1 and pix_ready=0; set rd_ptr=1 -> expect pix_ready=1, the next write at addr0, and wr_ptr=33.
REQ-039 SHALL: Send 5 pixels without sof after reset -> expect no ring_wr_en and wr_ptr=0.
REQ-040 SHALL: Send sof+A, then sof+B, then C -> expect sof_err=1 and a single write {C, B}.
REQ-041 SHALL: Pulse wr_rst_n low while in PACK_HI -> expect wr_ptr=0, no write of the held pixel, and WAIT_SOF behaviour on the next pixel.
